mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  asynchronous active-high reset.
REQ-002 The block SHALL have the port start  input  1  E-stage multiply/divide instruction valid; qualifies mdop.
REQ-003 The block SHALL have the port mdop  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 treated as none.
REQ-004 The block SHALL have the port A  input  32  forwarded rs operand from the E stage.
REQ-005 The block SHALL have the port B  input  32  forwarded rt operand from the E stage.
REQ-006 The block SHALL have the port D_mduse  input  1  instruction in D is one of mdop 1-8, driven by the hazard unit.
REQ-007 The block SHALL have the port busy  output  1  a mult or div is in flight.
REQ-008 The block SHALL have the port md_stall  output  1  combinational request to the hazard unit: D_mduse and (busy or accepted start of op 1-4).
REQ-009 The block SHALL have the port md_out  output  32  HI for mfhi, LO for mflo, 0 otherwise; combinational from the registers.

Function
REQ-010 An operation SHALL be accepted at a rising edge only when start=1 and busy=0; start while busy SHALL be ignored, with no state change.
REQ-011 On acceptance of op 1-4, the full result SHALL be computed into pending-HI/LO registers, and a counter SHALL load 5 for mult/multu or 10 for div/divu.
REQ-012 busy SHALL be high from the cycle after acceptance for exactly 5 cycles (mult) or 10 cycles (div), and the counter SHALL decrement once per cycle.
REQ-013 On the edge where the counter goes 1->0, pending values SHALL commit to HI/LO and busy SHALL fall in the same edge.
REQ-014 HI and LO SHALL be architecturally unchanged while busy=1.
REQ-015 mult SHALL form the signed 64-bit product and multu the unsigned product, with {HI,LO} = product.
REQ-016 div/divu SHALL set LO = quotient truncated toward zero and HI = remainder, where the signed remainder takes the sign of the dividend A.
REQ-017 For div/divu with B=0, the block SHALL still assert busy for 10 cycles and SHALL leave HI and LO unchanged on completion.
REQ-018 For signed div with A=0x80000000 and B=0xFFFFFFFF, the result SHALL be LO=0x80000000 and HI=0.
REQ-019 mthi/mtlo accepted per REQ-010 SHALL write A into HI or LO at that edge, with no busy period.
REQ-020 mfhi/mflo SHALL have no state effect, and md_out SHALL show the register value as of the current cycle.
REQ-021 md_stall SHALL be 0 whenever D_mduse=0.
REQ-022 The state machine SHALL have two states. IDLE -> BUSY on acceptance of op 1-4. BUSY -> IDLE when the counter reaches 0. No other transitions SHALL exist.

Reset
REQ-023 Asserting reset SHALL, without waiting for a clock edge, clear HI, LO, the pending registers and the counter to 0, force busy=0, and place the block in IDLE.
REQ-024 Reset during BUSY SHALL discard the in-flight result; the first start after reset release SHALL be accepted normally.
REQ-025 During reset, md_out SHALL be 0 and md_stall SHALL equal D_mduse and start.

Structure
REQ-026 The mdop encodings and the latencies 5 and 10 SHALL live in the shared pipeline constants header used by the controller and the hazard unit.
REQ-027 The arithmetic (signed/unsigned multiply, divide with the zero and overflow guards) SHALL reside in one sub-module, mdu_calc, which is purely combinational; mdu holds the state machine, counter and registers.

Verification
REQ-028 Scenario: reset; mult A=0xFFFFFFFF B=2 -> busy is high for 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=1, LO=0xFFFFFFFE.
REQ-029 Scenario: div A=-7 (0xFFFFFFF9) B=2 -> busy is high for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7 B=2 -> LO=3, HI=1.
REQ-030 Scenario: mthi 0x12345678, then div A=5 B=0 -> busy is high for 10 cycles; HI stays 0x12345678 and LO stays unchanged.
REQ-031 Scenario: mult accepted, then start with mtlo during cycle 3 of busy -> mtlo is ignored; after completion LO equals the product low word; D_mduse=1 during busy gives md_stall=1, and D_mduse=0 gives md_stall=0.
REQ-032 Scenario: div accepted, then reset pulsed at cycle 4 -> busy=0 immediately, HI=LO=0; a following mult 3x4 gives LO=12 after 5 cycles.
REQ-033 Scenario: mtlo 0xA5A5A5A5 then mflo in the next cycle -> md_out=0xA5A5A5A5 and md_stall=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared pipeline constants for the multiply/divide unit and its hazard logic.
// Holds the mdop encodings, the fixed operation latencies and the result record.
// No logic beyond a small decode helper.
package mdu_pkg;

    // mdop encodings; values 9-15 decode as no operation
    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_t;

    // cycles that busy stays high after a mult/div is accepted
    localparam logic [3:0] MULT_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT  = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    // full arithmetic result; wr=0 means HI/LO must be left untouched
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        wr;
    } md_res_t;

    // true for the long-latency ops (mult, multu, div, divu)
    function automatic logic is_arith(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath producing the full HI/LO result.
// Latency: zero (pure combinational); the caller times the busy window.
// No backpressure: result is valid whenever op/a/b are stable.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output md_res_t     res
);

    logic        signed_div;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        div_ovf;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    // Signed divide runs on magnitudes and fixes the signs afterwards, so a
    // single unsigned divider serves both div and divu.
    assign signed_div = (op == OP_DIV);
    assign mag_a      = (signed_div && a[31]) ? (32'd0 - a) : a;
    assign mag_b      = (signed_div && b[31]) ? (32'd0 - b) : b;
    // Never divide by zero; the result is discarded via wr=0 in that case.
    assign div_b      = (b == 32'd0) ? 32'd1 : mag_b;
    assign quo        = mag_a / div_b;
    assign rem        = mag_a % div_b;
    // -2^31 / -1 does not fit in 32 bits; it wraps to -2^31 with zero remainder.
    assign div_ovf    = signed_div && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Select the result for the requested operation.
    always_comb begin
        res = '0;
        case (op)
            OP_MULT: begin
                res.hi = prod_s[63:32];
                res.lo = prod_s[31:0];
                res.wr = 1'b1;
            end
            OP_MULTU: begin
                res.hi = prod_u[63:32];
                res.lo = prod_u[31:0];
                res.wr = 1'b1;
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    res.wr = 1'b0;
                end else if (div_ovf) begin
                    res.lo = 32'h8000_0000;
                    res.hi = 32'd0;
                    res.wr = 1'b1;
                end else begin
                    // quotient truncates toward zero; remainder follows the dividend
                    res.lo = (a[31] ^ b[31]) ? (32'd0 - quo) : quo;
                    res.hi = a[31] ? (32'd0 - rem) : rem;
                    res.wr = 1'b1;
                end
            end
            OP_DIVU: begin
                res.lo = quo;
                res.hi = rem;
                res.wr = (b != 32'd0);
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: HI/LO registers, fixed-latency busy window, hazard stall.
// Latency: mult/multu 5 cycles, div/divu 10 cycles; mthi/mtlo write at accept edge.
// Backpressure: start while busy is ignored; md_stall asks the hazard unit to hold D.
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_mduse,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] md_out
);

    md_state_t   state;
    md_state_t   state_nxt;
    logic [3:0]  cnt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_wr;
    logic        accept;
    logic        arith;
    md_res_t     calc_res;

    assign arith  = is_arith(mdop);
    assign accept = start && (state == ST_IDLE);

    mdu_calc u_calc (
        .op  (mdop),
        .a   (A),
        .b   (B),
        .res (calc_res)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the combinational outputs to the pipeline.
    always_comb begin
        state_nxt = state;
        busy      = (state == ST_BUSY);
        md_stall  = D_mduse && (busy || (start && arith));
        md_out    = 32'd0;
        case (state)
            ST_IDLE: if (accept && arith) state_nxt = ST_BUSY;
            ST_BUSY: if (cnt == 4'd1)     state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (start && (mdop == OP_MFHI)) begin
            md_out = hi;
        end else if (start && (mdop == OP_MFLO)) begin
            md_out = lo;
        end
    end

    // Counter, pending result and architectural HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 4'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else if (accept && arith) begin
            cnt     <= ((mdop == OP_MULT) || (mdop == OP_MULTU)) ? MULT_LAT : DIV_LAT;
            pend_hi <= calc_res.hi;
            pend_lo <= calc_res.lo;
            pend_wr <= calc_res.wr;
        end else if (accept && (mdop == OP_MTHI)) begin
            hi <= A;
        end else if (accept && (mdop == OP_MTLO)) begin
            lo <= A;
        end else if (state == ST_BUSY) begin
            cnt <= cnt - 4'd1;
            // commit on the final busy edge; a zero divisor leaves HI/LO alone
            if ((cnt == 4'd1) && pend_wr) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end
    end

endmodule
